// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC register feeding a 2-entry decode FIFO with misaligned-target fault marker
module fetch_unit #(
    parameter int ADDR_W   = 10,
    parameter int INST_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [INST_W-1:0] im_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_misalign
);

    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              misalign;
    } entry_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    entry_t            e0;
    entry_t            e1;
    entry_t            fetched;
    logic              pop;
    logic              fetch;

    assign im_addr      = pc;
    assign out_valid    = (count != 2'd0);
    assign out_inst     = e0.inst;
    assign out_pc       = e0.pc;
    assign out_misalign = e0.misalign;

    assign pop     = out_valid & out_ready;
    assign fetch   = (state == RUN) & ~redirect_valid & ((count < 2'd2) | pop);
    assign fetched = '{pc: pc, inst: im_inst, misalign: 1'b0};

    // e0 is always the head; e1 only holds data when count == 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= ADDR_W'(RESET_PC);
            count <= 2'd0;
            state <= RUN;
            e0    <= '0;
            e1    <= '0;
        end else if (redirect_valid) begin
            if (redirect_pc[1:0] == 2'b00) begin
                pc    <= redirect_pc;
                count <= 2'd0;
                state <= RUN;
            end else begin
                e0    <= '{pc: redirect_pc, inst: '0, misalign: 1'b1};
                count <= 2'd1;
                state <= FAULT;
            end
        end else begin
            if (fetch) begin
                pc <= pc + ADDR_W'(4);
            end
            case ({fetch, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= fetched;
                    else               e1 <= fetched;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= fetched;
                    end else begin
                        e0 <= e1;
                        e1 <= fetched;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed and randomized redirect/backpressure traffic
module tb_fetch_unit;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  im_addr;
    logic [31:0] im_inst;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [9:0]  out_pc;
    logic        out_misalign;

    logic [31:0] mem [256];
    exp_t        q[$];
    logic [9:0]  pc_m = '0;
    bit          fault_m = 1'b0;
    bit          started = 1'b0;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign im_inst = mem[im_addr[9:2]];

    fetch_unit #(.ADDR_W(10), .INST_W(32), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .im_addr(im_addr), .im_inst(im_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_misalign(out_misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the reference model predicts what the coming edge does.
    task automatic step(input logic r, input logic rv, input logic [9:0] rpc, input logic rdy);
        @(negedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        started        = 1'b1;
        if (r) begin
            q.delete();
            pc_m    = 10'h000;
            fault_m = 1'b0;
        end else if (rv) begin
            q.delete();
            if (rpc[1:0] == 2'b00) begin
                pc_m    = rpc;
                fault_m = 1'b0;
            end else begin
                q.push_back('{pc: rpc, inst: 32'h0, mis: 1'b1});
                fault_m = 1'b1;
            end
        end else if (!fault_m && (q.size() < 2 || rdy)) begin
            q.push_back('{pc: pc_m, inst: mem[pc_m[9:2]], mis: 1'b0});
            pc_m = pc_m + 10'd4;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 10'h042, 1'b1);
        step(1'b1, 1'b0, 10'h000, 1'b0);
        @(negedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_inst", out_inst, 32'h0);
        chk("reset out_pc", 32'(out_pc), 32'h0);
        chk("reset out_misalign", 32'(out_misalign), 32'h0);
        chk("reset im_addr", 32'(im_addr), 32'h0);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'h000, rdy);
    endtask

    // Monitor: compares the DUT head against the scoreboard, then retires on handshake.
    always begin
        @(negedge clk);
        if (started) begin
            chk("im_addr", 32'(im_addr), 32'(pc_m));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("out_pc", 32'(out_pc), 32'(q[0].pc));
                chk("out_inst", out_inst, q[0].inst);
                chk("out_misalign", 32'(out_misalign), 32'(q[0].mis));
            end
        end
        #2;
        if (started && !rst && !redirect_valid && out_valid && out_ready && q.size() != 0)
            void'(q.pop_front());
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        do_reset();
        run(6, 1'b1);

        do_reset();
        run(5, 1'b0);
        run(4, 1'b1);

        run(3, 1'b0);
        step(1'b0, 1'b1, 10'h040, 1'b1);
        run(3, 1'b1);

        step(1'b0, 1'b1, 10'h042, 1'b0);
        run(2, 1'b0);
        run(3, 1'b1);
        step(1'b0, 1'b1, 10'h080, 1'b1);
        run(3, 1'b1);

        step(1'b0, 1'b1, 10'h3FC, 1'b1);
        run(4, 1'b1);

        run(3, 1'b0);
        step(1'b0, 1'b1, 10'h013, 1'b0);
        run(2, 1'b0);
        do_reset();
        run(3, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic       rv;
            logic [9:0] rpc;
            rpc = 10'($urandom);
            if ($urandom_range(1) == 0) rpc[1:0] = 2'b00;
            rv = ($urandom_range(19) == 0);
            if ($urandom_range(199) == 0) step(1'b1, rv, rpc, 1'($urandom));
            else step(1'b0, rv, rpc, ($urandom_range(9) < 7));
        end

        run(4, 1'b1);
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
